serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller built around a single 1-bit full adder (sum = a^b^c, carry = majority(a,b,c)), instantiated or inlined inside this block.
- Latches two WIDTH-bit operands on a start request, then drives the full adder LSB-first for WIDTH cycles.
- Assembles the result in a shift register and reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency, in place of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); latched with operands
- op_a  input  WIDTH  operand A; latched on accepted start
- op_b  input  WIDTH  operand B; latched on accepted start
- cin  input  1  carry-in for add; ignored when sub=1
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; held stable from done until the next accepted start
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst=1 at a clk edge), taking priority over everything, including mid-operation:
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - An in-flight operation is discarded and produces no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch shA = op_a and shB = (sub ? ~op_b : op_b).
  - Set carry flop = (sub ? 1 : cin), cnt = 0, next state RUN.
  - Otherwise remain in IDLE; outputs hold.
- RUN (busy=1), each edge:
  - bit = shA[0]^shB[0]^carry.
  - Result register shifts right, inserting bit at MSB.
  - carry <= majority(shA[0], shB[0], carry).
  - shA and shB shift right; cnt++.
  - On the edge where cnt == WIDTH-1 (final bit):
    - ovf <= carry_in_of_MSB ^ carry_out_of_MSB.
    - cout <= carry_out.
    - sum is loaded from the completed result; next state DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
- start handling:
  - start while in RUN or DONE is ignored; no queuing.
  - The requester must re-assert start in IDLE.
- Timing:
  - If start is sampled at edge E0, busy is high for cycles E0+1 .. E0+WIDTH.
  - done is high in cycle E0+WIDTH+1.
  - The earliest next accepted start is sampled at edge E0+WIDTH+2.
  - Total latency is WIDTH+1 cycles; throughput is one operation per WIDTH+2 cycles.
- sum/cout/ovf update only at completion. They are not cleared by a new start; they keep their previous value until the new operation completes.
- Operand inputs are don't-care outside the accepting edge.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- done and busy are never high in the same cycle.

Test Plan:
- Add with signed overflow (WIDTH=8): op_a=0x5A, op_b=0x3C, cin=0, sub=0, start 1 cycle -> busy high 8 cycles, then done pulse with sum=0x96, cout=0, ovf=1.
- Carry wrap: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Repeat with cin=1 -> sum=0x01, cout=1, ovf=0.
- Subtract with borrow: sub=1, op_a=0x10, op_b=0x20, cin=1 (must be ignored) -> sum=0xF0, cout=0, ovf=0. Also sub=1, op_a=0x80, op_b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start while busy:
  - Start 0x01+0x01, then pulse start with op_a=0xAA, op_b=0x55 at the 3rd RUN cycle -> exactly one done, sum=0x02.
  - Hold start high continuously -> operations accepted every 10 cycles (WIDTH+2), never during RUN or DONE.
- Reset mid-operation:
  - Start 0x12+0x34, assert rst for 1 cycle at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done follows.
  - A subsequent start of 0x12+0x34 yields sum=0x46.
- Exhaustive check (WIDTH=4, optional): all 512 combinations of op_a, op_b, cin with sub=0 -> sum/cout match {cout,sum} = op_a+op_b+cin; ovf matches signed reference.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract using one full adder, LSB first, with sum/cout/ovf and done pulse
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sha, shb, res;
  logic             carry, fb, fc;
  logic [CW-1:0]    cnt;
  assign fb = sha[0] ^ shb[0] ^ carry;
  assign fc = (sha[0] & shb[0]) | (sha[0] & carry) | (shb[0] & carry);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      sha   <= '0;
      shb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sha   <= op_a;
          shb   <= sub ? ~op_b : op_b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          res   <= {fb, res[WIDTH-1:1]};
          carry <= fc;
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {fb, res[WIDTH-1:1]};
            cout  <= fc;
            ovf   <= carry ^ fc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;
  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;
  int               checks = 0, errors = 0;
  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic c, input logic [7:0] es, input logic ec, input logic eo);
    int nb = 0;
    int nd = 0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 8'hxx; op_b = 8'hxx;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, nb, WIDTH);
    chk({tag, "_early_done"}, nd, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
  endtask
  initial begin
    int nd, bad;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    op("add_ovf", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("wrap_cin", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    op("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    // start pulse mid-run must be ignored
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 3);
      if (i == 3) begin op_a = 8'hAA; op_b = 8'h55; end
      if (done) nd++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_start_dones", nd, 1);
    chk("busy_start_sum", sum, 8'h02);
    // continuous start: accepted every WIDTH+2 cycles
    op_a = 8'h01; op_b = 8'h02; start = 1'b1;
    @(negedge clk);
    nd = 0; bad = 0;
    for (int t = 1; t <= 40; t++) begin
      if (done) begin
        nd++;
        if (t % 10 != 9) bad++;
      end
      if (done && busy) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_start_dones", nd, 4);
    chk("hold_start_timing", bad, 0);
    chk("hold_start_sum", sum, 8'h03);
    repeat (12) @(negedge clk);
    // reset mid-operation discards the op and clears results
    op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("midrst_no_done", nd, 0);
    op("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
